// File: rtl/hazard_fwd_ctrl_if.sv
// Bundle between the ID stage and the hazard/forwarding controller: ID-stage
// instruction fields in, pipeline stall/flush/freeze controls and EX forwarding selects out.
interface hazard_fwd_ctrl_if #(
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
);
    logic               id_valid;
    logic [RADDR_W-1:0] id_rs;
    logic [RADDR_W-1:0] id_rt;
    logic               id_rs_used;
    logic               id_rt_used;
    logic [RADDR_W-1:0] id_rd;
    logic               id_regwrite;
    logic               id_memread;
    logic               id_jump;
    logic               mem_branch_taken;

    logic               pc_write;
    logic               ifid_write;
    logic               ctrl_bubble;
    logic               flush_ifid;
    logic               flush_idex;
    logic               flush_exmem;
    logic               freeze;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
               id_regwrite, id_memread, id_jump, mem_branch_taken,
        input  pc_write, ifid_write, ctrl_bubble, flush_ifid, flush_idex,
               flush_exmem, freeze, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
               id_regwrite, id_memread, id_jump, mem_branch_taken,
        output pc_write, ifid_write, ctrl_bubble, flush_ifid, flush_idex,
               flush_exmem, freeze, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Combined hazard detection and EX operand forwarding for the 5-stage pipeline.
// Define HAZ_STATS_EN to add saturating load-use stall and branch flush counters.
module hazard_fwd_ctrl #(
    parameter int RADDR_W = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input logic              clock,
    input logic              clear,
    hazard_fwd_ctrl_if.slave bus
);
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    // The writer in WB needs no tracking: the register file is write-through,
    // so a WB match resolves to the regfile path anyway.
    logic               ex_v;
    logic [RADDR_W-1:0] ex_rd;
    logic               ex_ld;
    logic               mem_v;
    logic [RADDR_W-1:0] mem_rd;

    logic [LAT_W-1:0]   lat_cnt;
    logic [1:0]         fwd_a_q, fwd_b_q;
    logic [1:0]         fwd_a_nxt, fwd_b_nxt;

    logic frozen, load_use, branch, issue, jump, stall, id_v;
    logic ex_rs, ex_rt, mem_rs, mem_rt;

    function automatic logic hit(input logic v, input logic [RADDR_W-1:0] rd,
                                 input logic [RADDR_W-1:0] src, input logic used);
        return used & v & (rd == src) & (src != '0);
    endfunction

    assign frozen   = (lat_cnt != '0);
    assign id_v     = bus.id_regwrite & (bus.id_rd != '0);
    assign ex_rs    = hit(ex_v, ex_rd, bus.id_rs, bus.id_rs_used);
    assign ex_rt    = hit(ex_v, ex_rd, bus.id_rt, bus.id_rt_used);
    assign mem_rs   = hit(mem_v, mem_rd, bus.id_rs, bus.id_rs_used);
    assign mem_rt   = hit(mem_v, mem_rd, bus.id_rt, bus.id_rt_used);
    assign load_use = bus.id_valid & ex_ld & (ex_rs | ex_rt) & ~frozen;
    assign branch   = bus.mem_branch_taken & ~frozen;
    assign issue    = bus.id_valid & ~load_use & ~branch & ~frozen;
    assign jump     = bus.id_jump & issue;
    assign stall    = load_use & ~branch;

    always_comb begin
        bus.pc_write    = 1'b1;
        bus.ifid_write  = 1'b1;
        bus.ctrl_bubble = 1'b0;
        bus.flush_ifid  = 1'b0;
        bus.flush_idex  = 1'b0;
        bus.flush_exmem = 1'b0;
        // Reset forces the idle response even while ID/MEM inputs are still active.
        if (!clear) begin
            if (frozen) begin
                bus.pc_write   = 1'b0;
                bus.ifid_write = 1'b0;
            end else if (branch) begin
                bus.ctrl_bubble = 1'b1;
                bus.flush_ifid  = 1'b1;
                bus.flush_idex  = 1'b1;
                bus.flush_exmem = 1'b1;
            end else if (load_use) begin
                bus.pc_write    = 1'b0;
                bus.ifid_write  = 1'b0;
                bus.ctrl_bubble = 1'b1;
            end else if (jump) begin
                bus.flush_ifid = 1'b1;
            end
        end
    end

    always_comb begin
        fwd_a_nxt = 2'b00;
        fwd_b_nxt = 2'b00;
        if (issue) begin
            if (ex_rs)       fwd_a_nxt = 2'b10;
            else if (mem_rs) fwd_a_nxt = 2'b01;
            if (ex_rt)       fwd_b_nxt = 2'b10;
            else if (mem_rt) fwd_b_nxt = 2'b01;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            ex_v    <= 1'b0;
            ex_rd   <= '0;
            ex_ld   <= 1'b0;
            mem_v   <= 1'b0;
            mem_rd  <= '0;
            lat_cnt <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else if (frozen) begin
            lat_cnt <= lat_cnt - 1'b1;
        end else begin
            fwd_a_q <= fwd_a_nxt;
            fwd_b_q <= fwd_b_nxt;
            if (branch) begin
                ex_v  <= 1'b0;
                ex_ld <= 1'b0;
                mem_v <= 1'b0;
            end else begin
                mem_v  <= ex_v;
                mem_rd <= ex_rd;
                ex_v   <= issue & id_v;
                ex_rd  <= bus.id_rd;
                ex_ld  <= issue & bus.id_memread;
                // A surviving load entering MEM starts the memory-latency freeze.
                if (ex_ld) lat_cnt <= LAT_LOAD;
            end
        end
    end

    assign bus.freeze = frozen;
    assign bus.fwd_a  = fwd_a_q;
    assign bus.fwd_b  = fwd_b_q;

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall && stall_q != '1)  stall_q <= stall_q + 1'b1;
            if (branch && flush_q != '1) flush_q <= flush_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed vector table, queue-free age-based reference
// model for random stimulus (MEM_LAT=1), and hand sequences for freeze and reset.
module tb_hazard_fwd_ctrl;
    logic clock = 1'b0;
    logic clear_a, clear_b;
    always #5 clock = ~clock;

    hazard_fwd_ctrl_if #(.RADDR_W(5), .CNT_W(2))  ifa ();
    hazard_fwd_ctrl_if #(.RADDR_W(5), .CNT_W(16)) ifb ();

    hazard_fwd_ctrl #(.RADDR_W(5), .MEM_LAT(1), .CNT_W(2))  dut_a (.clock(clock), .clear(clear_a), .bus(ifa));
    hazard_fwd_ctrl #(.RADDR_W(5), .MEM_LAT(3), .CNT_W(16)) dut_b (.clock(clock), .clear(clear_b), .bus(ifb));

    typedef struct {
        logic v; logic [4:0] rs; logic [4:0] rt; logic rsu; logic rtu;
        logic [4:0] rd; logic rw; logic mr; logic jmp; logic br;
    } stim_t;
    typedef struct {
        stim_t s; logic [6:0] ec; logic [1:0] fa; logic [1:0] fb; string nm;
    } vec_t;
    typedef struct { logic wr; logic [4:0] rd; logic ld; } ent_t;

    // {pc_write, ifid_write, ctrl_bubble, flush_ifid, flush_idex, flush_exmem, freeze}
    localparam logic [6:0] NORM  = 7'b1100000;
    localparam logic [6:0] STALL = 7'b0010000;
    localparam logic [6:0] BRF   = 7'b1111110;
    localparam logic [6:0] JMP   = 7'b1101000;
    localparam logic [6:0] FRZ   = 7'b0000001;
    localparam int SAT_A = 3;

    int n_tests = 0;
    int n_fail  = 0;
    ent_t hist [2];   // [0] instruction now in EX, [1] in MEM
    int m_stall, m_flush;
    vec_t tbl [$];

    function automatic stim_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic rsu, input logic rtu, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic jmp, input logic br);
        stim_t s;
        s = '{v, rs, rt, rsu, rtu, rd, rw, mr, jmp, br};
        return s;
    endfunction
    function automatic stim_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return mk(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic stim_t ld(input logic [4:0] rd, input logic [4:0] rs);
        return mk(1'b1, rs, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic stim_t nop();
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic stim_t with_br(input stim_t s);
        stim_t t;
        t = s;
        t.br = 1'b1;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---- reference model: forwarding by producer age, stalls by rule ----
    function automatic logic writes(input ent_t e, input logic [4:0] r, input logic used);
        return used && e.wr && (e.rd == r) && (r != 5'd0);
    endfunction
    function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic used);
        for (int k = 0; k < 2; k++)
            if (writes(hist[k], r, used)) return (k == 0) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction
    function automatic logic m_lu(input stim_t s);
        return s.v && hist[0].ld && (writes(hist[0], s.rs, s.rsu) || writes(hist[0], s.rt, s.rtu));
    endfunction
    function automatic void predict(input stim_t s, output logic [6:0] ec,
                                    output logic [1:0] fa, output logic [1:0] fb);
        logic lu, iss;
        lu  = m_lu(s);
        iss = s.v && !lu && !s.br;
        ec  = {s.br || !lu, s.br || !lu, s.br || lu, s.br || (iss && s.jmp), s.br, s.br, 1'b0};
        fa  = iss ? fwd_sel(s.rs, s.rsu) : 2'b00;
        fb  = iss ? fwd_sel(s.rt, s.rtu) : 2'b00;
    endfunction
    function automatic void commit(input stim_t s);
        logic lu, iss;
        ent_t inv;
        inv = '{1'b0, 5'd0, 1'b0};
        lu  = m_lu(s);
        iss = s.v && !lu && !s.br;
        if (lu && !s.br && m_stall < SAT_A) m_stall++;
        if (s.br && m_flush < SAT_A) m_flush++;
        if (s.br) begin
            hist[1] = inv;
            hist[0] = inv;
        end else begin
            hist[1] = hist[0];
            hist[0] = iss ? '{s.rw && (s.rd != 5'd0), s.rd, s.mr} : inv;
        end
    endfunction
    function automatic void model_reset();
        hist[0] = '{1'b0, 5'd0, 1'b0};
        hist[1] = '{1'b0, 5'd0, 1'b0};
        m_stall = 0;
        m_flush = 0;
    endfunction

    function automatic logic [6:0] ctrl_a();
        return {ifa.pc_write, ifa.ifid_write, ifa.ctrl_bubble, ifa.flush_ifid,
                ifa.flush_idex, ifa.flush_exmem, ifa.freeze};
    endfunction
    function automatic logic [6:0] ctrl_b();
        return {ifb.pc_write, ifb.ifid_write, ifb.ctrl_bubble, ifb.flush_ifid,
                ifb.flush_idex, ifb.flush_exmem, ifb.freeze};
    endfunction

    task automatic drive_a(input stim_t s);
        ifa.id_valid = s.v; ifa.id_rs = s.rs; ifa.id_rt = s.rt;
        ifa.id_rs_used = s.rsu; ifa.id_rt_used = s.rtu; ifa.id_rd = s.rd;
        ifa.id_regwrite = s.rw; ifa.id_memread = s.mr; ifa.id_jump = s.jmp;
        ifa.mem_branch_taken = s.br;
    endtask
    task automatic drive_b(input stim_t s);
        ifb.id_valid = s.v; ifb.id_rs = s.rs; ifb.id_rt = s.rt;
        ifb.id_rs_used = s.rsu; ifb.id_rt_used = s.rtu; ifb.id_rd = s.rd;
        ifb.id_regwrite = s.rw; ifb.id_memread = s.mr; ifb.id_jump = s.jmp;
        ifb.mem_branch_taken = s.br;
    endtask

    task automatic check_cnt_a(input string nm);
`ifdef HAZ_STATS_EN
        chk({nm, " counters"}, 32'({ifa.stall_cnt, ifa.flush_cnt}), 32'({2'(m_stall), 2'(m_flush)}));
`else
        chk({nm, " counters"}, 32'({ifa.stall_cnt, ifa.flush_cnt}), 32'd0);
`endif
    endtask

    // Called at posedge+1: apply ID inputs, check same-cycle controls, then EX selects.
    task automatic step_a(input stim_t s, input logic [6:0] ec, input logic [1:0] fa,
                          input logic [1:0] fb, input string nm);
        drive_a(s);
        @(negedge clock);
        chk({nm, " ctrl"}, 32'(ctrl_a()), 32'(ec));
        commit(s);
        @(posedge clock); #1;
        chk({nm, " fwd"}, 32'({ifa.fwd_a, ifa.fwd_b}), 32'({fa, fb}));
        check_cnt_a(nm);
    endtask
    task automatic step_m(input stim_t s, input string nm);
        logic [6:0] ec;
        logic [1:0] fa, fb;
        predict(s, ec, fa, fb);
        step_a(s, ec, fa, fb, nm);
    endtask
    task automatic step_b(input stim_t s, input logic [6:0] ec, input logic [1:0] fa,
                          input logic [1:0] fb, input string nm);
        drive_b(s);
        @(negedge clock);
        chk({nm, " ctrl"}, 32'(ctrl_b()), 32'(ec));
        @(posedge clock); #1;
        chk({nm, " fwd"}, 32'({ifb.fwd_a, ifb.fwd_b}), 32'({fa, fb}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s, jr3;
        jr3 = mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl.push_back('{alu(3, 1, 2),            NORM,  2'b00, 2'b00, "t1 producer"});
        tbl.push_back('{alu(4, 3, 5),            NORM,  2'b10, 2'b00, "t1 exmem fwd"});
        tbl.push_back('{nop(),                   NORM,  2'b00, 2'b00, "t1 nop"});
        tbl.push_back('{alu(6, 4, 3),            NORM,  2'b01, 2'b00, "t1 memwb fwd"});
        tbl.push_back('{ld(2, 1),                NORM,  2'b00, 2'b00, "t2 load"});
        tbl.push_back('{alu(4, 2, 2),            STALL, 2'b00, 2'b00, "t2 load-use"});
        tbl.push_back('{alu(4, 2, 2),            NORM,  2'b01, 2'b01, "t2 after bubble"});
        tbl.push_back('{alu(7, 1, 1),            NORM,  2'b00, 2'b00, "t4 writer r7"});
        tbl.push_back('{with_br(alu(8, 7, 7)),   BRF,   2'b00, 2'b00, "t4 branch flush"});
        tbl.push_back('{alu(9, 7, 7),            NORM,  2'b00, 2'b00, "t4 no fwd after flush"});
        tbl.push_back('{alu(0, 1, 2),            NORM,  2'b00, 2'b00, "t5 write r0"});
        tbl.push_back('{alu(4, 0, 0),            NORM,  2'b00, 2'b00, "t5 read r0"});
        tbl.push_back('{ld(0, 1),                NORM,  2'b00, 2'b00, "t5 load r0"});
        tbl.push_back('{alu(5, 0, 0),            NORM,  2'b00, 2'b00, "t5 use r0 after load"});
        tbl.push_back('{mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0),
                                                 JMP,   2'b00, 2'b00, "jump flush"});
        tbl.push_back('{ld(3, 1),                NORM,  2'b00, 2'b00, "load r3"});
        tbl.push_back('{jr3,                     STALL, 2'b00, 2'b00, "jump held by stall"});
        tbl.push_back('{jr3,                     JMP,   2'b01, 2'b00, "jump after stall"});
        tbl.push_back('{ld(2, 1),                NORM,  2'b00, 2'b00, "load r2"});
        tbl.push_back('{with_br(alu(4, 2, 2)),   BRF,   2'b00, 2'b00, "branch over load-use"});
        tbl.push_back('{alu(1, 2, 2),            NORM,  2'b00, 2'b00, "after flush of load"});

        // Reset with active inputs must still present the idle response.
        clear_a = 1'b1; clear_b = 1'b1;
        s = with_br(ld(2, 1));
        s.jmp = 1'b1;
        drive_a(s); drive_b(s);
        #2;
        chk("reset ctrl a", 32'(ctrl_a()), 32'(NORM));
        chk("reset ctrl b", 32'(ctrl_b()), 32'(NORM));
        chk("reset fwd a", 32'({ifa.fwd_a, ifa.fwd_b}), 32'd0);
        check_cnt_a("reset");
        model_reset();
        drive_a(nop()); drive_b(nop());
        @(negedge clock);
        clear_a = 1'b0; clear_b = 1'b0;
        @(posedge clock); #1;

        foreach (tbl[i]) step_a(tbl[i].s, tbl[i].ec, tbl[i].fa, tbl[i].fb, tbl[i].nm);

        for (int i = 0; i < 400; i++) begin
            s = mk($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            step_m(s, "rand");
        end

        // Reset in the middle of a load-use stall.
        clear_a = 1'b1; #2;
        model_reset();
        drive_a(nop());
        @(negedge clock); clear_a = 1'b0;
        @(posedge clock); #1;
        step_a(ld(2, 1), NORM, 2'b00, 2'b00, "t6 load");
        drive_a(alu(4, 2, 2));
        @(negedge clock);
        chk("t6 stall before clear", 32'(ctrl_a()), 32'(STALL));
        #1 clear_a = 1'b1;
        #1;
        chk("t6 clear mid-stall ctrl", 32'(ctrl_a()), 32'(NORM));
        chk("t6 clear mid-stall fwd", 32'({ifa.fwd_a, ifa.fwd_b}), 32'd0);
        model_reset();
        check_cnt_a("t6 clear mid-stall");
        drive_a(nop());
        #1 clear_a = 1'b0;
        @(posedge clock); #1;

        // Counter sequence: one stall and one flush, then enough stalls to saturate.
        step_a(ld(2, 1),              NORM,  2'b00, 2'b00, "cnt load");
        step_a(alu(4, 2, 2),          STALL, 2'b00, 2'b00, "cnt stall");
        step_a(alu(4, 2, 2),          NORM,  2'b01, 2'b01, "cnt resume");
        step_a(with_br(alu(5, 1, 1)), BRF,   2'b00, 2'b00, "cnt flush");
`ifdef HAZ_STATS_EN
        chk("stall_cnt one", 32'(ifa.stall_cnt), 32'd1);
        chk("flush_cnt one", 32'(ifa.flush_cnt), 32'd1);
`endif
        for (int i = 0; i < 5; i++) begin
            step_m(ld(2, 1), "sat load");
            step_m(alu(4, 2, 2), "sat stall");
            step_m(alu(4, 2, 2), "sat resume");
        end
`ifdef HAZ_STATS_EN
        chk("stall_cnt saturated", 32'(ifa.stall_cnt), 32'd3);
`endif

        // MEM_LAT=3: two frozen cycles per load; held state; branch ignored while frozen.
        step_b(alu(1, 8, 8),          NORM,  2'b00, 2'b00, "b producer r1");
        step_b(ld(2, 1),              NORM,  2'b10, 2'b00, "b load r2");
        step_b(alu(4, 1, 5),          NORM,  2'b01, 2'b00, "b alu1");
        step_b(with_br(alu(7, 2, 4)), FRZ,   2'b01, 2'b00, "b frozen 1");
        step_b(alu(7, 2, 4),          FRZ,   2'b01, 2'b00, "b frozen 2");
        step_b(alu(7, 2, 4),          NORM,  2'b01, 2'b10, "b alu2 after freeze");
        step_b(ld(3, 0),              NORM,  2'b00, 2'b00, "b load r3");
        step_b(alu(9, 3, 0),          STALL, 2'b00, 2'b00, "b load-use");
        step_b(alu(9, 3, 0),          FRZ,   2'b00, 2'b00, "b lu frozen 1");
        step_b(alu(9, 3, 0),          FRZ,   2'b00, 2'b00, "b lu frozen 2");
        step_b(alu(9, 3, 0),          NORM,  2'b01, 2'b00, "b lu resume");
        step_b(ld(5, 1),              NORM,  2'b00, 2'b00, "b load r5");
        step_b(nop(),                 NORM,  2'b00, 2'b00, "b nop");
        chk("b freeze entered", 32'(ifb.freeze), 32'd1);
        clear_b = 1'b1;
        #1;
        chk("b clear mid-freeze ctrl", 32'(ctrl_b()), 32'(NORM));
        chk("b clear mid-freeze fwd", 32'({ifb.fwd_a, ifb.fwd_b}), 32'd0);
        drive_b(nop());
        @(negedge clock); clear_b = 1'b0;
        @(posedge clock); #1;
        step_b(alu(6, 5, 5),          NORM,  2'b00, 2'b00, "b after clear");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
